// File: rtl/mu0_mux_n_reg.sv
// N-way registered multiplexer with valid/ready handshake.
// Direct select on S or round-robin scan over the channels.
module mu0_mux_n_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                         Clk,
  input  logic                         nReset,
  input  logic [CHANNELS*WIDTH-1:0]    D,
  input  logic [$clog2(CHANNELS)-1:0]  S,
  input  logic                         Mode,
  input  logic                         InValid,
  output logic                         InReady,
  output logic [WIDTH-1:0]             Q,
  output logic [$clog2(CHANNELS)-1:0]  QSel,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic                         Err
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic             accept;
  logic             drain;
  logic [SEL_W-1:0] ch;
  logic             oor;
  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;

  assign InReady = !OutValid || OutReady;
  assign accept  = InValid && InReady;
  assign drain   = OutValid && OutReady;

  assign ch  = Mode ? ptr : S;
  assign oor = int'(ch) >= CHANNELS;

  assign ptr_nxt = (ptr == LAST) ? '0 : ptr + SEL_W'(1);

  // Pick the chosen channel; unmatched (out-of-range) selects give zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch == SEL_W'(k)) sel_data = D[k*WIDTH +: WIDTH];
    end
  end

  // Output register: load on accept, clear valid on a pure drain.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      Q        <= '0;
      QSel     <= '0;
      Err      <= 1'b0;
      OutValid <= 1'b0;
    end else if (accept) begin
      Q        <= sel_data;
      QSel     <= ch;
      Err      <= oor;
      OutValid <= 1'b1;
    end else if (drain) begin
      OutValid <= 1'b0;
    end
  end

  // Scan pointer moves only on accepts taken in scan mode.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      ptr <= '0;
    end else if (accept && Mode) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mu0_mux_n_reg.sv
// Bench for mu0_mux_n_reg with CHANNELS=3.
// Directed plan followed by random traffic against a queue-free model.
module tb_mu0_mux_n_reg;

  localparam int W  = 16;
  localparam int CH = 3;

  logic          Clk = 1'b0;
  logic          nReset;
  logic [CH*W-1:0] D;
  logic [1:0]    S;
  logic          Mode;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  Q;
  logic [1:0]    QSel;
  logic          OutValid;
  logic          OutReady;
  logic          Err;

  logic [W-1:0]  dv [CH];

  int total = 0;
  int bad   = 0;

  int          m_v;
  logic [W-1:0] m_q;
  int          m_sel;
  int          m_err;
  int          m_ptr;

  assign D = {dv[2], dv[1], dv[0]};

  always #5 Clk = ~Clk;

  mu0_mux_n_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .Clk(Clk), .nReset(nReset), .D(D), .S(S), .Mode(Mode),
    .InValid(InValid), .InReady(InReady), .Q(Q), .QSel(QSel),
    .OutValid(OutValid), .OutReady(OutReady), .Err(Err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check handshake, advance model, check registers.
  task automatic tick();
    int          rdy, acc, drn, c;
    int          n_v, n_sel, n_err, n_ptr;
    logic [W-1:0] n_q;
    #1;
    rdy = (m_v == 0 || OutReady) ? 1 : 0;
    chk("in_ready", {31'd0, InReady}, rdy);
    acc = (InValid && rdy) ? 1 : 0;
    drn = (m_v != 0 && OutReady) ? 1 : 0;
    n_v = m_v; n_q = m_q; n_sel = m_sel;
    n_err = m_err; n_ptr = m_ptr;
    if (!nReset) begin
      n_v = 0; n_q = '0; n_sel = 0; n_err = 0; n_ptr = 0;
    end else if (acc != 0) begin
      c     = Mode ? m_ptr : int'(S);
      n_q   = (c < CH) ? dv[c] : '0;
      n_sel = c;
      n_err = (c >= CH) ? 1 : 0;
      n_v   = 1;
      if (Mode) n_ptr = (m_ptr + 1) % CH;
    end else if (drn != 0) begin
      n_v = 0;
    end
    @(posedge Clk);
    #1;
    m_v = n_v; m_q = n_q; m_sel = n_sel;
    m_err = n_err; m_ptr = n_ptr;
    chk("q", {16'd0, Q}, {16'd0, m_q});
    chk("qsel", {30'd0, QSel}, m_sel);
    chk("out_valid", {31'd0, OutValid}, m_v);
    chk("err", {31'd0, Err}, m_err);
  endtask

  initial begin
    m_v = 0; m_q = '0; m_sel = 0; m_err = 0; m_ptr = 0;
    dv[0] = 16'h1234; dv[1] = 16'h4321; dv[2] = 16'h7777;
    nReset = 1'b0; InValid = 1'b1; OutReady = 1'b1;
    Mode = 1'b0; S = 2'd0;

    // reset
    @(posedge Clk);
    #1;
    tick();
    tick();
    chk("rst_q", {16'd0, Q}, 32'h0);
    chk("rst_ready", {31'd0, InReady}, 32'd1);

    // direct select
    nReset = 1'b1;
    S = 2'd0; tick();
    chk("dir_s0", {16'd0, Q}, 32'h1234);
    S = 2'd2; tick();
    chk("dir_s2", {16'd0, Q}, 32'h7777);

    // backpressure
    S = 2'd1; tick();
    OutReady = 1'b0; S = 2'd0; dv[1] = 16'h2222;
    repeat (3) tick();
    chk("bp_hold", {16'd0, Q}, 32'h4321);
    OutReady = 1'b1; tick();
    chk("bp_release", {16'd0, Q}, 32'h1234);
    dv[1] = 16'h4321;

    // round-robin wrap and resume
    Mode = 1'b1;
    repeat (5) tick();
    Mode = 1'b0; S = 2'd0;
    repeat (2) tick();
    Mode = 1'b1; tick();
    chk("rr_resume", {30'd0, QSel}, 32'd2);

    // out-of-range select
    Mode = 1'b0; S = 2'd3; tick();
    chk("oor_err", {31'd0, Err}, 32'd1);
    S = 2'd1; tick();
    chk("oor_clear", {16'd0, Q}, 32'h4321);

    // reset mid-operation
    Mode = 1'b1;
    repeat (2) tick();
    OutReady = 1'b0; tick();
    nReset = 1'b0; tick();
    chk("mid_rst_valid", {31'd0, OutValid}, 32'd0);
    nReset = 1'b1; OutReady = 1'b1; tick();
    chk("mid_rst_ptr", {30'd0, QSel}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      nReset   = ($urandom_range(0, 39) != 0);
      InValid  = $urandom_range(0, 3) != 0;
      OutReady = $urandom_range(0, 2) != 0;
      Mode     = $urandom_range(0, 1) != 0;
      S        = 2'($urandom_range(0, 3));
      for (int k = 0; k < CH; k++) dv[k] = 16'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mu0_mux_n_reg.md
Name: mu0_mux_n_reg

Overview:
Parametrised N-way, WIDTH-bit multiplexer with a registered output stage and a valid/ready handshake. It generalises the MU0 16-bit 2:1 datapath mux to CHANNELS inputs. It adds two selection modes: direct select, and an automatic round-robin scan. It is used to feed the MU0 bus and debug capture paths, where a source must be selected and held under backpressure.

Parameters:
WIDTH, 16, data width of each channel and of Q
CHANNELS, 4, number of input channels, legal range 2..16; internal localparam SEL_W = $clog2(CHANNELS)

Ports:
Clk  input  1  system clock; all state updates on the rising edge
nReset  input  1  synchronous, active-low reset
D  input  CHANNELS*WIDTH  flattened channel data; channel k occupies D[k*WIDTH +: WIDTH]
S  input  SEL_W  channel select, used in direct mode only
Mode  input  1  0 = direct select on S; 1 = round-robin scan
InValid  input  1  source offers a transfer this cycle
InReady  output  1  block can accept a transfer this cycle
Q  output  WIDTH  registered selected data
QSel  output  SEL_W  channel index that produced Q
OutValid  output  1  Q/QSel/Err hold a valid item
OutReady  input  1  sink accepts Q this cycle
Err  output  1  registered flag: item was taken with an out-of-range select

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (nReset = 0 at a rising edge of Clk):
  - Q = 0, QSel = 0, OutValid = 0, Err = 0, scan pointer Ptr = 0.
  - Reset overrides all other activity, including a transfer in flight: any held item is discarded.
- Handshake:
  - InReady = !OutValid || OutReady. This is combinational and passes OutReady through.
  - accept = InValid && InReady.
  - drain = OutValid && OutReady.
- Channel choice ch:
  - Mode 0: ch = S.
  - Mode 1: ch = Ptr.
- On accept, the next edge loads:
  - Q <= channel ch of D, or all zeros if ch >= CHANNELS.
  - QSel <= ch.
  - Err <= (ch >= CHANNELS).
  - OutValid <= 1.
- Latency: exactly 1 cycle from accept to OutValid/Q.
- Throughput: 1 item per cycle when OutReady is held at 1.
- Drain only (drain && !accept): OutValid <= 0. Q, QSel and Err keep their values.
- Simultaneous drain and accept: the new item replaces the old one and OutValid stays 1. No bubble, no loss.
- Backpressure (OutValid = 1, OutReady = 0):
  - InReady = 0.
  - Q, QSel, Err and OutValid are all frozen.
  - Changes on D, S and Mode have no effect.
- Scan pointer Ptr (SEL_W bits):
  - Advances only on an accept made while Mode = 1.
  - Wraps from CHANNELS-1 to 0.
  - Holds its value while Mode = 0. Returning to Mode 1 resumes from the held Ptr.
  - Never takes a value >= CHANNELS, so Err is only reachable in Mode 0.
- Mode may change on any cycle. It takes effect for the accept in that same cycle.
- D is sampled only on the accepting edge. Q is never combinationally transparent to D.
- There is no behaviour for X on S or Mode beyond simulation X-propagation.

Test Plan:
1. Reset: hold nReset = 0 for 2 edges with InValid = 1 -> Q = 16'h0000, QSel = 0, OutValid = 0, Err = 0, InReady = 1. Then release reset.
2. Direct select, with CHANNELS = 3, D0 = 16'h1234, D1 = 16'h4321, D2 = 16'h7777, Mode = 0, OutReady = 1, InValid = 1:
   - S = 0 -> next cycle Q = 16'h1234, QSel = 0.
   - S = 2 -> next cycle Q = 16'h7777, QSel = 2.
   - Each result appears 1 cycle after the accept.
3. Backpressure: accept S = 1 (Q = 16'h4321), then OutReady = 0 for 3 cycles while S = 0 and D1 changes to 16'h2222 -> Q stays 16'h4321, OutValid = 1, InReady = 0. Raise OutReady with InValid = 1 -> Q = 16'h1234 on the next edge with no idle cycle.
4. Round-robin wrap: Mode = 1, CHANNELS = 3, InValid = OutReady = 1 for 5 cycles -> QSel sequence 0,1,2,0,1 with Q = 1234,4321,7777,1234,4321. Switch to Mode 0 for 2 accepts, then back to Mode 1 -> QSel resumes at 2.
5. Out-of-range: Mode = 0, CHANNELS = 3, S = 3 -> Q = 16'h0000, QSel = 3, Err = 1. Next accept with S = 1 -> Err = 0, Q = 16'h4321.
6. Reset mid-operation: OutValid = 1 under backpressure with Ptr = 2, then assert nReset for 1 edge -> all outputs return to reset values. After release, the next Mode 1 accept gives QSel = 0.
